// File: rtl/logic_unit_pkg.sv
// Shared types for the streaming logic unit: opcode encoding, the flag half
// of a result FIFO entry, and the FIFO occupancy states.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_NOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_XNOR = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // A FIFO entry is packed as {err, zero, result}; the result width is a
    // module parameter, so only the fixed-width flag part is a struct here.
    typedef struct packed {
        logic err;
        logic zero;
    } entry_flags_t;

    localparam int FLAG_W = 2;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'b00,
        FIFO_PARTIAL = 2'b01,
        FIFO_FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/logic_result_fifo.sv
// Result FIFO for logic_unit_stream: storage, wrapping pointers, occupancy
// count and an EMPTY/PARTIAL/FULL state machine that tracks the count.
// Storage is not reset; the top gates head data with out_valid.
module logic_result_fifo
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH+FLAG_W-1:0]       wr_data,
    output logic [WIDTH+FLAG_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH+FLAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    fifo_state_e             state;
    fifo_state_e             state_next;
    logic [CW-1:0]           count_next;
    logic                    do_push;
    logic                    do_pop;

    // Push is refused when full, pop is refused when empty.
    always_comb begin
        do_push    = push && (state != FIFO_FULL);
        do_pop     = pop && (state != FIFO_EMPTY);
        count_next = count;
        state_next = state;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        case (state)
            FIFO_EMPTY: begin
                if (do_push)
                    state_next = FIFO_PARTIAL;
            end
            FIFO_PARTIAL: begin
                if (do_push && !do_pop && (count == DEPTH_C - ONE_C))
                    state_next = FIFO_FULL;
                else if (do_pop && !do_push && (count == ONE_C))
                    state_next = FIFO_EMPTY;
            end
            FIFO_FULL: begin
                if (do_pop)
                    state_next = FIFO_PARTIAL;
            end
            default: state_next = FIFO_EMPTY;
        endcase
    end

    // Control state: pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= FIFO_EMPTY;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            state <= state_next;
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/logic_unit_stream.sv
// Streaming bitwise logic unit: one opcode + operand pair per input
// handshake, result and flags queued in logic_result_fifo and drained
// through the output handshake.
// Optional feature macro: LOGIC_ACC_EN adds in_acc_sel and an accumulator
// that can stand in for operand a and loads every accepted result.
module logic_unit_stream
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
`ifdef LOGIC_ACC_EN
    input  logic                   in_acc_sel,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_zero,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [WIDTH-1:0] calc_result(
        input op_e              op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            OP_AND:  calc_result = a & b;
            OP_OR:   calc_result = a | b;
            OP_XOR:  calc_result = a ^ b;
            OP_NOT:  calc_result = ~a;
            OP_NOR:  calc_result = ~(a | b);
            OP_NAND: calc_result = ~(a & b);
            OP_XNOR: calc_result = ~(a ^ b);
            default: calc_result = '0;
        endcase
    endfunction

    logic                    vld_p0;
    logic [WIDTH-1:0]        opa_p0;
    logic [WIDTH-1:0]        res_p0;
    entry_flags_t            flags_p0;
    logic [WIDTH+FLAG_W-1:0] head_data;
    entry_flags_t            head_flags;
    logic                    pop;

`ifdef LOGIC_ACC_EN
    logic [WIDTH-1:0]        acc;
`endif

    // ---- stage p0: accept, operand select, compute and flag ----
    always_comb begin
        in_ready = !reset && (count < DEPTH_C);
        vld_p0   = in_valid && in_ready;
`ifdef LOGIC_ACC_EN
        opa_p0   = in_acc_sel ? acc : in_a;
`else
        opa_p0   = in_a;
`endif
        res_p0        = calc_result(op_e'(in_op), opa_p0, in_b);
        flags_p0.err  = (in_op == OP_RSVD);
        flags_p0.zero = (res_p0 == '0);
    end

`ifdef LOGIC_ACC_EN
    // Accumulator follows every enqueued result, reserved opcodes included.
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (vld_p0)
            acc <= res_p0;
    end
`endif

    // ---- FIFO boundary: entries become visible at the head after the push edge ----
    logic_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (vld_p0),
        .pop     (pop),
        .wr_data ({flags_p0, res_p0}),
        .rd_data (head_data),
        .count   (count)
    );

    // Head outputs are forced to zero when the FIFO holds nothing.
    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid && out_ready;
        head_flags = entry_flags_t'(head_data[WIDTH+FLAG_W-1:WIDTH]);
        out_result = out_valid ? head_data[WIDTH-1:0] : '0;
        out_zero   = out_valid ? head_flags.zero : 1'b0;
        out_err    = out_valid ? head_flags.err : 1'b0;
    end

endmodule

// File: tb/tb_logic_unit_stream.sv
// Directed bench for logic_unit_stream (WIDTH=8, DEPTH=4). Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_logic_unit_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_acc_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_err;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_stream #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
`ifdef LOGIC_ACC_EN
        .in_acc_sel (in_acc_sel),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .count      (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_a = 8'h00; in_b = 8'h00;
        in_acc_sel = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, count, out_result, out_zero, out_err} !== 14'd0) begin
            errors++;
            $display("FAIL rst_outputs got v=%b c=%0d r=%h z=%b e=%b want all 0",
                     out_valid, count, out_result, out_zero, out_err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_opcodes();
        logic [7:0] exp [7] = '{8'h0A, 8'hAF, 8'hA5, 8'hF0, 8'h50, 8'hF5, 8'h5A};
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h0F; in_b = 8'hAA;
        for (int i = 0; i < 7; i++) begin
            in_op = 3'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp[i] || out_zero !== 1'b0 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL op%0d got v=%b r=%h z=%b e=%b want v=1 r=%h z=0 e=0",
                         i, out_valid, out_result, out_zero, out_err, exp[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL op_drain got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_flags();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b000; in_a = 8'h00; in_b = 8'hFF;
        step();
        checks++;
        if (out_result !== 8'h00 || out_zero !== 1'b1 || out_err !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL and_zero got r=%h z=%b e=%b v=%b want r=00 z=1 e=0 v=1",
                               out_result, out_zero, out_err, out_valid);
        end
        out_ready = 1'b1;
        in_op = 3'b111; in_a = 8'hFF; in_b = 8'hFF;
        step();
        checks++;
        if (out_result !== 8'h00 || out_zero !== 1'b1 || out_err !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rsvd got r=%h z=%b e=%b v=%b want r=00 z=1 e=1 v=1",
                               out_result, out_zero, out_err, out_valid);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL flags_drain got c=%0d want 0", count); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b000; in_b = 8'hFF;
        for (int i = 1; i <= 4; i++) begin
            in_a = 8'(i);
            step();
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_count got c=%0d rdy=%b want c=4 rdy=0", count, in_ready);
        end
        in_a = 8'h05;
        step();
        checks++;
        if (count !== 3'd4 || out_result !== 8'h01) begin
            errors++; $display("FAIL full_hold got c=%0d r=%h want c=4 r=01", count, out_result);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_result !== 8'h02) begin
            errors++; $display("FAIL full_pop got c=%0d rdy=%b r=%h want c=3 rdy=1 r=02",
                               count, in_ready, out_result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL full_fifth got c=%0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 8'(i)) begin
                errors++; $display("FAIL full_drain%0d got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, 8'(i));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got v=%b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b001; in_b = 8'h00;
        in_a = 8'd1; step();
        in_a = 8'd2; step();
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_a = 8'(j + 3);
            step();
            checks++;
            if (count !== 3'd2 || out_result !== 8'(j + 2)) begin
                errors++; $display("FAIL b2b%0d got c=%0d r=%h want c=2 r=%h", j, count, out_result, 8'(j + 2));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_result !== 8'd11) begin errors++; $display("FAIL b2b_tail0 got %h want 0b", out_result); end
        step();
        checks++;
        if (out_result !== 8'd12 || count !== 3'd1) begin
            errors++; $display("FAIL b2b_tail1 got r=%h c=%0d want r=0c c=1", out_result, count);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b010; in_a = 8'h33; in_b = 8'h0F;
        step(); step(); step();
        reset = 1'b1;
        step();
        checks++;
        if ({out_valid, count, out_result, out_zero, out_err, in_ready} !== 15'd0) begin
            errors++; $display("FAIL flush got v=%b c=%0d r=%h z=%b e=%b rdy=%b want all 0",
                               out_valid, count, out_result, out_zero, out_err, in_ready);
        end
        reset = 1'b0;
        in_op = 3'b000; in_a = 8'hF0; in_b = 8'hAA;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 8'hA0 || count !== 3'd1) begin
            errors++; $display("FAIL flush_next got r=%h c=%0d want r=a0 c=1", out_result, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

`ifdef LOGIC_ACC_EN
    task automatic test_acc();
        logic [2:0] ops [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
        logic       sel [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp [4] = '{8'h0F, 8'hF0, 8'h0F, 8'h0F};
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h00;
        for (int i = 0; i < 4; i++) begin
            in_op = ops[i]; in_acc_sel = sel[i];
            in_b = (i == 0) ? 8'h00 : 8'hFF;
            if (i == 1) in_a = 8'h55;
            step();
            checks++;
            if (out_result !== exp[i]) begin
                errors++; $display("FAIL acc%0d got %h want %h", i, out_result, exp[i]);
            end
        end
        in_valid = 1'b0; in_acc_sel = 1'b0;
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_opcodes();
        test_flags();
        test_full();
        test_back_to_back();
        test_reset_flush();
`ifdef LOGIC_ACC_EN
        test_acc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
